request_arbiter: RTL and testbench

- Registered N-way arbiter built around the priority encoder function. It turns a request vector into a single one-hot grant plus an encoded index.
- Supports fixed-priority and round-robin selection, with optional grant holding until the request drops or an acknowledge arrives.
- Sits directly upstream of muxes and demuxes, which consume grant and grant_encoded to steer data.

---
 rtl/request_arbiter.sv | 133 +++++++++++++
 tb/tb_request_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/request_arbiter.sv
// request_arbiter: registered N-way arbiter producing a one-hot grant and
// its encoded index. Fixed-priority or round-robin selection, with optional
// grant holding on request or acknowledge.
// Optional feature: define REQUEST_ARBITER_TIMEOUT_EN to force-release a held
// grant after TIMEOUT cycles and pulse grant_timeout.
module request_arbiter #(
  parameter int PORTS        = 4,
  parameter     TYPE         = "PRIORITY",
  parameter     BLOCK        = "NONE",
  parameter     LSB_PRIORITY = "LOW",
  parameter int TIMEOUT      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORTS-1:0]           request,
  input  logic [PORTS-1:0]           acknowledge,
  output logic [PORTS-1:0]           grant,
  output logic                       grant_valid,
  output logic [$clog2(PORTS)-1:0]   grant_encoded
`ifdef REQUEST_ARBITER_TIMEOUT_EN
  ,
  output logic                       grant_timeout
`endif
);

  localparam int IW           = $clog2(PORTS);
  localparam bit ROUND_ROBIN  = (TYPE == "ROUND_ROBIN");
  localparam bit HIGH_FIRST   = (LSB_PRIORITY == "HIGH");
  localparam bit HOLD_REQUEST = (BLOCK == "REQUEST");
  localparam bit HOLD_ACK     = (BLOCK == "ACKNOWLEDGE");

  if (PORTS < 2 || TIMEOUT < 1) begin : g_bad_config
    $error("request_arbiter: PORTS must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t           state;
  logic [PORTS-1:0] mask;
  logic [PORTS-1:0] next_mask;
  logic [IW-1:0]    winner;
  logic             hold;
  logic             keep;
  logic             expire;

  // Priority encoder: lowest set bit for LOW, highest set bit for HIGH.
  function automatic logic [IW-1:0] pick(input logic [PORTS-1:0] v);
    logic [IW-1:0] idx;
    logic          found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (v[i] && (HIGH_FIRST || !found)) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

`ifdef REQUEST_ARBITER_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] hold_count;
`endif

  // Hold decision, winner selection and the mask that follows a new grant.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    hold      = 1'b0;
    expire    = 1'b0;
    winner    = '0;
    next_mask = '0;
    if (state == GRANTED) begin
      if (HOLD_REQUEST)  hold = request[grant_encoded];
      else if (HOLD_ACK) hold = !acknowledge[grant_encoded];
    end
`ifdef REQUEST_ARBITER_TIMEOUT_EN
    expire = hold && (hold_count == CW'(TIMEOUT - 1));
`endif
    keep = hold && !expire;
    if (ROUND_ROBIN && |(request & mask)) winner = pick(request & mask);
    else                                  winner = pick(request);
    for (int j = 0; j < PORTS; j++) begin
      next_mask[j] = HIGH_FIRST ? (j < int'(winner)) : (j > int'(winner));
    end
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      // NOTE: the rotation mask is reset to all ones so the first
      // round-robin pick behaves exactly like fixed priority.
      mask          <= '1;
`ifdef REQUEST_ARBITER_TIMEOUT_EN
      hold_count    <= '0;
      grant_timeout <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
`ifdef REQUEST_ARBITER_TIMEOUT_EN
      grant_timeout <= expire;
`endif
      if (keep) begin
`ifdef REQUEST_ARBITER_TIMEOUT_EN
        hold_count <= hold_count + 1'b1;
`endif
      end else begin
`ifdef REQUEST_ARBITER_TIMEOUT_EN
        hold_count <= '0;
`endif
        if (|request) begin
          state         <= GRANTED;
          grant         <= {{(PORTS-1){1'b0}}, 1'b1} << winner;
          grant_valid   <= 1'b1;
          grant_encoded <= winner;
          if (ROUND_ROBIN) mask <= next_mask;
        end else begin
          state         <= IDLE;
          grant         <= '0;
          grant_valid   <= 1'b0;
          grant_encoded <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_request_arbiter.sv
// tb_request_arbiter: six arbiter configurations share one stimulus stream.
// A pointer-based reference model predicts every output each cycle; directed
// phases add hand-computed literal expectations.
module tb_request_arbiter;

  localparam int P = 4;
  localparam int N = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [P-1:0] request     = '0;
  logic [P-1:0] acknowledge = '0;

  logic [N-1:0][P-1:0] g;
  logic [N-1:0]        gv;
  logic [N-1:0][1:0]   ge;
  logic [N-1:0]        gt;

  int checks = 0;
  int errors = 0;

  // Per-instance configuration: rr 1 = round robin; block 0 none, 1 request,
  // 2 acknowledge; high 1 = index P-1 highest priority.
  string name     [N] = '{"fp", "rr_low", "rr_high", "hold_req", "hold_ack", "timeout"};
  int    cfg_rr   [N] = '{0, 1, 1, 0, 1, 1};
  int    cfg_block[N] = '{0, 0, 0, 1, 2, 2};
  int    cfg_high [N] = '{0, 0, 1, 1, 0, 0};
  int    cfg_to   [N] = '{16, 16, 16, 16, 16, 4};

  always #5 clk = ~clk;

  request_arbiter #(.PORTS(P), .TYPE("PRIORITY"), .BLOCK("NONE"), .LSB_PRIORITY("LOW"), .TIMEOUT(16)) u_fp (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g[0]), .grant_valid(gv[0]), .grant_encoded(ge[0])
`ifdef REQUEST_ARBITER_TIMEOUT_EN
    , .grant_timeout(gt[0])
`endif
  );
  request_arbiter #(.PORTS(P), .TYPE("ROUND_ROBIN"), .BLOCK("NONE"), .LSB_PRIORITY("LOW"), .TIMEOUT(16)) u_rr_low (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g[1]), .grant_valid(gv[1]), .grant_encoded(ge[1])
`ifdef REQUEST_ARBITER_TIMEOUT_EN
    , .grant_timeout(gt[1])
`endif
  );
  request_arbiter #(.PORTS(P), .TYPE("ROUND_ROBIN"), .BLOCK("NONE"), .LSB_PRIORITY("HIGH"), .TIMEOUT(16)) u_rr_high (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g[2]), .grant_valid(gv[2]), .grant_encoded(ge[2])
`ifdef REQUEST_ARBITER_TIMEOUT_EN
    , .grant_timeout(gt[2])
`endif
  );
  request_arbiter #(.PORTS(P), .TYPE("PRIORITY"), .BLOCK("REQUEST"), .LSB_PRIORITY("HIGH"), .TIMEOUT(16)) u_hold_req (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g[3]), .grant_valid(gv[3]), .grant_encoded(ge[3])
`ifdef REQUEST_ARBITER_TIMEOUT_EN
    , .grant_timeout(gt[3])
`endif
  );
  request_arbiter #(.PORTS(P), .TYPE("ROUND_ROBIN"), .BLOCK("ACKNOWLEDGE"), .LSB_PRIORITY("LOW"), .TIMEOUT(16)) u_hold_ack (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g[4]), .grant_valid(gv[4]), .grant_encoded(ge[4])
`ifdef REQUEST_ARBITER_TIMEOUT_EN
    , .grant_timeout(gt[4])
`endif
  );
  request_arbiter #(.PORTS(P), .TYPE("ROUND_ROBIN"), .BLOCK("ACKNOWLEDGE"), .LSB_PRIORITY("LOW"), .TIMEOUT(4)) u_timeout (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(g[5]), .grant_valid(gv[5]), .grant_encoded(ge[5])
`ifdef REQUEST_ARBITER_TIMEOUT_EN
    , .grant_timeout(gt[5])
`endif
  );

`ifndef REQUEST_ARBITER_TIMEOUT_EN
  assign gt = '0;
`endif

  task automatic check(input string what, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", what, actual, expected);
    end
  endtask

  // Reference model: a "last winner" pointer instead of a mask; round robin
  // searches outward from the pointer in priority direction with wrap-around.
  bit m_valid[N];
  int m_idx  [N];
  int m_last [N];
  int m_cnt  [N];
  bit m_to   [N];

  function automatic int fixed_pick(input int k, input logic [P-1:0] r);
    if (cfg_high[k] != 0) begin
      for (int i = P - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int i = 0; i < P; i++) if (r[i]) return i;
    end
    return 0;
  endfunction

  function automatic int rr_pick(input int k, input logic [P-1:0] r);
    for (int s = 1; s <= P; s++) begin
      int c;
      c = (cfg_high[k] != 0) ? (m_last[k] - s + 2 * P) % P : (m_last[k] + s) % P;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  task automatic model_reset(input int k);
    m_valid[k] = 1'b0;
    m_idx[k]   = 0;
    m_last[k]  = (cfg_high[k] != 0) ? 0 : P - 1;
    m_cnt[k]   = 0;
    m_to[k]    = 1'b0;
  endtask

  task automatic model_step(input int k);
    bit hold;
    bit fire;
    int w;
    hold = m_valid[k] && ((cfg_block[k] == 1 && request[m_idx[k]]) ||
                          (cfg_block[k] == 2 && !acknowledge[m_idx[k]]));
    fire = 1'b0;
`ifdef REQUEST_ARBITER_TIMEOUT_EN
    if (hold && m_cnt[k] == cfg_to[k] - 1) begin
      hold = 1'b0;
      fire = 1'b1;
    end
`endif
    m_to[k] = fire;
    if (hold) begin
      m_cnt[k]++;
    end else begin
      m_cnt[k] = 0;
      if (request == '0) begin
        m_valid[k] = 1'b0;
        m_idx[k]   = 0;
      end else begin
        w = (cfg_rr[k] != 0) ? rr_pick(k, request) : fixed_pick(k, request);
        m_valid[k] = 1'b1;
        m_idx[k]   = w;
        if (cfg_rr[k] != 0) m_last[k] = w;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < N; k++) begin
      if (rst) model_reset(k);
      else     model_step(k);
    end
  end

  // Compare process: all instances against the model, away from the edge.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s grant", name[k]), 32'(g[k]), m_valid[k] ? (32'd1 << m_idx[k]) : 32'd0);
      check($sformatf("%s valid", name[k]), 32'(gv[k]), 32'(m_valid[k]));
      check($sformatf("%s encoded", name[k]), 32'(ge[k]), m_valid[k] ? 32'(m_idx[k]) : 32'd0);
      check($sformatf("%s timeout", name[k]), 32'(gt[k]), 32'(m_to[k]));
    end
  end

  // Drive inputs at a falling edge, return at the next falling edge.
  task automatic apply(input logic [P-1:0] r, input logic [P-1:0] a);
    request     = r;
    acknowledge = a;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    request     = '0;
    acknowledge = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int seq_low [4];
    int seq_high[4];
    seq_low  = '{0, 1, 2, 3};
    seq_high = '{2, 1, 0, 2};

    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset grant", 32'(g[0]), 32'h0);
    check("reset valid", 32'(gv[0]), 32'h0);
    check("reset encoded", 32'(ge[0]), 32'h0);
    check("reset timeout", 32'(gt[5]), 32'h0);
    rst = 1'b0;

    // Fixed priority, LOW.
    apply(4'b1010, 4'b0000);
    check("fp grant 1010", 32'(g[0]), 32'b0010);
    check("fp encoded 1010", 32'(ge[0]), 32'd1);
    check("fp valid 1010", 32'(gv[0]), 32'd1);
    apply(4'b0000, 4'b0000);
    check("fp grant idle", 32'(g[0]), 32'h0);
    check("fp valid idle", 32'(gv[0]), 32'h0);
    check("fp encoded idle", 32'(ge[0]), 32'h0);

    // Round robin LOW, all requesting, then wrap.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(4'b1111, 4'b0000);
      check($sformatf("rr_low step %0d", i), 32'(ge[1]), 32'(seq_low[i]));
    end
    apply(4'b1001, 4'b0000);
    check("rr_low wrap to 0", 32'(ge[1]), 32'd0);
    apply(4'b1001, 4'b0000);
    check("rr_low next 3", 32'(ge[1]), 32'd3);
    apply(4'b1111, 4'b0000);
    check("rr_low wrap again", 32'(ge[1]), 32'd0);

    // Round robin HIGH.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(4'b0111, 4'b0000);
      check($sformatf("rr_high step %0d", i), 32'(ge[2]), 32'(seq_high[i]));
    end

    // Hold on request (fixed priority, HIGH).
    do_reset();
    apply(4'b0101, 4'b0000);
    check("hold_req first", 32'(g[3]), 32'b0100);
    for (int i = 0; i < 5; i++) begin
      apply(4'b0101, 4'b0000);
      check($sformatf("hold_req held %0d", i), 32'(g[3]), 32'b0100);
    end
    apply(4'b0001, 4'b0000);
    check("hold_req release", 32'(g[3]), 32'b0001);
    check("hold_req no gap", 32'(gv[3]), 32'd1);
    apply(4'b0000, 4'b0000);
    check("hold_req idle", 32'(g[3]), 32'h0);

    // Hold on acknowledge (round robin, LOW), then asynchronous reset.
    do_reset();
    apply(4'b0010, 4'b0000);
    check("hold_ack first", 32'(g[4]), 32'b0010);
    apply(4'b0010, 4'b0001);
    check("hold_ack wrong ack", 32'(g[4]), 32'b0010);
    apply(4'b1010, 4'b0010);
    check("hold_ack handoff", 32'(g[4]), 32'b1000);
    check("hold_ack no gap", 32'(gv[4]), 32'd1);
    request     = 4'b1000;
    acknowledge = 4'b0000;
    #2 rst = 1'b1;
    #1;
    check("async reset grant", 32'(g[4]), 32'h0);
    check("async reset valid", 32'(gv[4]), 32'h0);
    check("async reset encoded", 32'(ge[4]), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Forced release after TIMEOUT cycles of holding.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(4'b0011, 4'b0000);
      check($sformatf("timeout hold %0d", i), 32'(g[5]), 32'b0001);
      check($sformatf("timeout quiet %0d", i), 32'(gt[5]), 32'd0);
    end
    apply(4'b0011, 4'b0000);
`ifdef REQUEST_ARBITER_TIMEOUT_EN
    check("timeout release grant", 32'(g[5]), 32'b0010);
    check("timeout pulse", 32'(gt[5]), 32'd1);
`else
    check("unbounded hold grant", 32'(g[5]), 32'b0001);
    check("no timeout pulse", 32'(gt[5]), 32'd0);
`endif
    apply(4'b0011, 4'b0000);
`ifdef REQUEST_ARBITER_TIMEOUT_EN
    check("timeout after grant", 32'(g[5]), 32'b0010);
    check("timeout pulse ends", 32'(gt[5]), 32'd0);
`else
    check("unbounded hold grant 2", 32'(g[5]), 32'b0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
